// File: rtl/alu_mul_seq_if.sv
// ---------------------------------------------------------------------------
// alu_mul_seq_if
//   Bundles the execute-stage request/result signals and the shared-ALU
//   drive/return signals of the shift-add multiplier sequencer.
//
//   Request side  : start, op_a, op_b            (execute stage -> sequencer)
//   Result side   : busy, done, product          (sequencer -> execute stage)
//   ALU side      : alu_a, alu_b, alu_ctrl,
//                   alu_flag                     (sequencer -> ALU)
//                   alu_out                      (ALU -> sequencer, combinational)
//
//   modport slave  : the sequencer's view
//   modport master : the surrounding pipeline / ALU view
// ---------------------------------------------------------------------------
interface alu_mul_seq_if #(
   parameter int WIDTH = 8
) ();

   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] product;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_ctrl;
   logic             alu_flag;
   logic [WIDTH-1:0] alu_out;

   modport slave (
      input  start, op_a, op_b, alu_out,
      output busy, done, product, alu_a, alu_b, alu_ctrl, alu_flag
   );

   modport master (
      output start, op_a, op_b, alu_out,
      input  busy, done, product, alu_a, alu_b, alu_ctrl, alu_flag
   );

endinterface

// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq
//   Multi-cycle shift-add multiplier sequencer. Forms the low WIDTH bits of
//   op_a * op_b by issuing ADD, SLL and SRL operations on the shared ALU,
//   three cycles per multiplier bit (ADD -> SHL -> SHR), whether or not the
//   bit adds. The ALU ports carry the idle value (all zero) unless busy.
//
//   Parameters
//     WIDTH      operand/result width, must match the ALU data width
//     EARLY_EXIT 1: finish as soon as the shifted multiplier reaches zero
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous, active-high reset (aborts a running op)
//     bus.start  request, sampled only in IDLE or DONE
//     bus.op_a   multiplicand, captured on the accepting edge
//     bus.op_b   multiplier, captured on the accepting edge
//     bus.busy   high in ADD/SHL/SHR
//     bus.done   one-cycle pulse, product valid from this cycle on
//     bus.product low WIDTH bits of the product, held until the next done
//     bus.alu_a/alu_b/alu_ctrl/alu_flag  ALU drive
//     bus.alu_out ALU result, consumed in the same cycle
// ---------------------------------------------------------------------------
module alu_mul_seq #(
   parameter int WIDTH      = 8,
   parameter bit EARLY_EXIT = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   alu_mul_seq_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [2:0] CTRL_ADD   = 3'b000;
   localparam logic [2:0] CTRL_SHIFT = 3'b011;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADD,
      S_SHL,
      S_SHR,
      S_DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [CW-1:0]    cnt;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] product;

   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_ctrl;
   logic             alu_flag;

   logic             last_bit;

   // ALU drive is a pure decode of the state register and datapath
   // registers; start never reaches the ALU ports.
   always_comb begin
      alu_a    = '0;
      alu_b    = '0;
      alu_ctrl = CTRL_ADD;
      alu_flag = 1'b0;
      case (state)
         S_ADD: begin
            alu_a = acc;
            alu_b = mcand;
         end
         S_SHL: begin
            alu_a    = mcand;
            alu_b    = WIDTH'(1);
            alu_ctrl = CTRL_SHIFT;
            alu_flag = 1'b1;
         end
         S_SHR: begin
            alu_a    = mplier;
            alu_b    = WIDTH'(1);
            alu_ctrl = CTRL_SHIFT;
            alu_flag = 1'b0;
         end
         default: ;
      endcase
   end

   // Terminate after WIDTH bits, or earlier once no set multiplier bits
   // remain (the freshly shifted value is what the ALU returns in SHR).
   assign last_bit = (cnt == CW'(1)) ||
                     (EARLY_EXIT && (bus.alu_out == '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         cnt     <= '0;
      end else begin
         case (state)
            // IDLE and DONE both accept a new request, which makes
            // back-to-back operations lose no cycle beyond the DONE pulse.
            S_IDLE, S_DONE: begin
               done <= 1'b0;
               if (bus.start) begin
                  acc    <= '0;
                  mcand  <= bus.op_a;
                  mplier <= bus.op_b;
                  cnt    <= CW'(WIDTH);
                  busy   <= 1'b1;
                  state  <= S_ADD;
               end else begin
                  state  <= S_IDLE;
               end
            end

            // Conditional accumulate: the ADD slot is always spent so
            // every bit costs the same three cycles.
            S_ADD: begin
               if (mplier[0]) begin
                  acc <= bus.alu_out;
               end
               state <= S_SHL;
            end

            S_SHL: begin
               mcand <= bus.alu_out;
               state <= S_SHR;
            end

            S_SHR: begin
               mplier <= bus.alu_out;
               cnt    <= cnt - CW'(1);
               if (last_bit) begin
                  product <= acc;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  state   <= S_ADD;
               end
            end

            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.product  = product;
   assign bus.alu_a    = alu_a;
   assign bus.alu_b    = alu_b;
   assign bus.alu_ctrl = alu_ctrl;
   assign bus.alu_flag = alu_flag;

endmodule
